// File: rtl/program_counter_v3_pkg.sv
// Shared CPU definitions for the program counter: instruction codes, the
// instruction size and helpers that classify codes.
package program_counter_v3_pkg;

    typedef enum logic [6:0] {
        IC_BEQ    = 7'd30,
        IC_BGEZ   = 7'd31,
        IC_BGEZAL = 7'd32,
        IC_BGTZ   = 7'd33,
        IC_BLEZ   = 7'd34,
        IC_BLTZ   = 7'd35,
        IC_BLTZAL = 7'd36,
        IC_BNE    = 7'd37,
        IC_J      = 7'd38,
        IC_JAL    = 7'd39,
        IC_JALR   = 7'd40,
        IC_JR     = 7'd41
    } internal_code_e;

    localparam int INSTR_BYTES = 4;

    // Instructions that write a return address, taken or not.
    function automatic logic is_link_code(input logic [6:0] code);
        return (code == IC_JAL) || (code == IC_JALR) ||
               (code == IC_BGEZAL) || (code == IC_BLTZAL);
    endfunction

    // PC-relative conditional branches (BEQ..BNE).
    function automatic logic is_branch_code(input logic [6:0] code);
        return (code >= IC_BEQ) && (code <= IC_BNE);
    endfunction

endpackage

// File: rtl/program_counter_v3_if.sv
// Bus between the CPU control sequencer and the program counter.
interface program_counter_v3_if #(
    parameter int ADDR_W = 32
);
    logic              fetch;
    logic              exec1;
    logic              exec2;
    logic              stall;
    logic [6:0]        internal_code;
    logic [15:0]       offset;
    logic [25:0]       instr_index;
    logic [ADDR_W-1:0] register_data;
    logic              zero;
    logic              positive;
    logic              negative;
    logic [ADDR_W-1:0] address;
    logic              halt;
    logic [ADDR_W-1:0] link_address;
    logic              link_en;
    logic              in_delay_slot;

    modport master (
        output fetch, exec1, exec2, stall, internal_code, offset, instr_index,
               register_data, zero, positive, negative,
        input  address, halt, link_address, link_en, in_delay_slot
    );

    modport slave (
        input  fetch, exec1, exec2, stall, internal_code, offset, instr_index,
               register_data, zero, positive, negative,
        output address, halt, link_address, link_en, in_delay_slot
    );
endinterface

// File: rtl/program_counter_v3_branch_resolver.sv
// Combinational branch resolver: decides whether a code redirects the PC and
// whether it links or takes its target from a register.
module program_counter_v3_branch_resolver
    import program_counter_v3_pkg::*;
(
    input  logic [6:0] internal_code,
    input  logic       zero,
    input  logic       positive,
    input  logic       negative,
    output logic       taken,
    output logic       is_link,
    output logic       is_reg
);

    always_comb begin
        taken = 1'b0;
        case (internal_code)
            IC_BEQ:                taken = zero;
            IC_BNE:                taken = !zero;
            IC_BGEZ, IC_BGEZAL:    taken = positive || zero;
            IC_BGTZ:               taken = positive;
            IC_BLEZ:               taken = negative || zero;
            IC_BLTZ, IC_BLTZAL:    taken = negative;
            IC_J, IC_JAL,
            IC_JR, IC_JALR:        taken = 1'b1;
            default:               taken = 1'b0;
        endcase
    end

    assign is_link = is_link_code(internal_code);
    assign is_reg  = (internal_code == IC_JR) || (internal_code == IC_JALR);

endmodule

// File: rtl/program_counter_v3.sv
// Multicycle CPU program counter: sequential fetch, jumps, conditional
// branches, optional branch delay slot, link address and sticky halt.
module program_counter_v3
    import program_counter_v3_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(32'hBFC00000),
    parameter logic [ADDR_W-1:0] HALT_ADDR    = '0,
    parameter bit                DELAY_SLOT   = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    program_counter_v3_if.slave  bus
);

    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] LINK_STEP = ADDR_W'(2 * INSTR_BYTES);

    logic [ADDR_W-1:0] address_reg, address_next;
    logic [ADDR_W-1:0] target_reg, target_next;
    logic [ADDR_W-1:0] pending_target_reg, pending_target_next;
    logic              halt_reg, halt_next;
    logic              take_reg, take_next;
    logic              pending_reg, pending_next;

    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] target;
    logic              taken;
    logic              is_link;
    logic              is_reg;

    program_counter_v3_branch_resolver u_resolver (
        .internal_code (bus.internal_code),
        .zero          (bus.zero),
        .positive      (bus.positive),
        .negative      (bus.negative),
        .taken         (taken),
        .is_link       (is_link),
        .is_reg        (is_reg)
    );

    assign seq_addr      = address_reg + STEP;
    assign branch_target = seq_addr + {{(ADDR_W-18){bus.offset[15]}}, bus.offset, 2'b00};

    // J/JAL keep the top nibble of the sequential address when it exists.
    generate
        if (ADDR_W > 28) begin : g_jump_wide
            assign jump_target = {seq_addr[ADDR_W-1:28], bus.instr_index, 2'b00};
        end else begin : g_jump_narrow
            assign jump_target = ADDR_W'({bus.instr_index, 2'b00});
        end
    endgenerate

    always_comb begin
        target = jump_target;
        if (is_reg) begin
            target = bus.register_data;
        end else if (is_branch_code(bus.internal_code)) begin
            target = branch_target;
        end
    end

    always_comb begin
        address_next        = address_reg;
        halt_next           = halt_reg;
        take_next           = take_reg;
        target_next         = target_reg;
        pending_next        = pending_reg;
        pending_target_next = pending_target_reg;

        if (!bus.stall && !halt_reg) begin
            if (bus.fetch && (address_reg == HALT_ADDR)) begin
                halt_next = 1'b1;
            end
            // A redirect resolved inside a delay slot is dropped.
            if (bus.exec1) begin
                take_next   = taken && !pending_reg;
                target_next = target;
            end
            if (bus.exec2) begin
                take_next = 1'b0;
                if (DELAY_SLOT) begin
                    address_next = pending_reg ? pending_target_reg : seq_addr;
                    pending_next = take_reg;
                    if (take_reg) begin
                        pending_target_next = target_reg;
                    end
                end else begin
                    address_next = take_reg ? target_reg : seq_addr;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address_reg        <= RESET_VECTOR;
            halt_reg           <= 1'b0;
            take_reg           <= 1'b0;
            target_reg         <= RESET_VECTOR;
            pending_reg        <= 1'b0;
            pending_target_reg <= RESET_VECTOR;
        end else begin
            address_reg        <= address_next;
            halt_reg           <= halt_next;
            take_reg           <= take_next;
            target_reg         <= target_next;
            pending_reg        <= pending_next;
            pending_target_reg <= pending_target_next;
        end
    end

    assign bus.address       = address_reg;
    assign bus.halt          = halt_reg;
    assign bus.link_address  = address_reg + LINK_STEP;
    assign bus.link_en       = !reset && (bus.exec1 || bus.exec2) && is_link;
    assign bus.in_delay_slot = pending_reg;

endmodule

// File: doc/program_counter_v3.md
Name: program_counter_v3

Overview:
- Parametrised successor to the multicycle CPU's program counter; the same fetch/exec1/exec2 sequencing drives it.
- Holds the instruction address and resolves J/JAL/JR/JALR and the conditional branches from the ALU flags.
- Generalised over address width, reset vector, halt address and delay-slot mode.
- Adds a memory stall input, a link-address output and a delay-slot status flag.

Parameters:
- ADDR_W, 32: width of address, register_data and link_address.
- RESET_VECTOR, 32'hBFC00000: address loaded on reset.
- HALT_ADDR, 0: fetching this address halts the CPU.
- DELAY_SLOT, 1: 1 gives a MIPS branch delay slot; 0 applies the redirect immediately.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- fetch, exec1, exec2  in  1 each  one-hot CPU state.
- stall  in  1  memory waitrequest; freezes all state updates.
- internal_code  in  7  decoded instruction code.
- offset  in  16  branch immediate.
- instr_index  in  26  J/JAL target field.
- register_data  in  ADDR_W  rs value for JR/JALR.
- zero, positive, negative  in  1 each  comparison flags, valid during exec1.
- address  out  ADDR_W  current PC.
- halt  out  1  CPU halted, sticky.
- link_address  out  ADDR_W  return address.
- link_en  out  1  current instruction writes a link.
- in_delay_slot  out  1  current instruction is a delay slot.

Behaviour:
- Reset values (asynchronous): address=RESET_VECTOR; halt=0; link_en=0; link_address=RESET_VECTOR+8; in_delay_slot=0; pending=0.
- Any update is suppressed on an edge where stall=1 or halt=1.

Internal codes: J=38, JAL=39, JALR=40, JR=41, BEQ=30, BGEZ=31, BGEZAL=32, BGTZ=33, BLEZ=34, BLTZ=35, BLTZAL=36, BNE=37. Any other code means no redirect.

Taken conditions:
- BEQ: zero. BNE: !zero.
- BGEZ and BGEZAL: positive|zero. BGTZ: positive.
- BLEZ: negative|zero. BLTZ and BLTZAL: negative.
- J, JAL, JR and JALR are always taken.

Targets (wrap modulo 2^ADDR_W):
- Branch: address+4+(sign-extended offset<<2).
- J/JAL: {(address+4)[ADDR_W-1:28], instr_index, 2'b00}.
- JR/JALR: register_data.

Sequencing:
- At the exec1 edge, a taken instruction latches target_q and sets take_q.
- JAL, JALR, BGEZAL and BLTZAL assert link_en and drive link_address=address+8 from exec1 through the end of exec2. The link is written whether or not the branch is taken.
- At the exec2 edge with DELAY_SLOT=1:
  - If pending=1: address<=pending_target and pending clears.
  - Else: address<=address+4.
  - If take_q: pending<=1, pending_target<=target_q, and in_delay_slot=1 for the next instruction.
- At the exec2 edge with DELAY_SLOT=0: address<=take_q ? target_q : address+4.
- A taken branch inside a delay slot is discarded. The pending target still applies.
- Halt: an edge with fetch=1, stall=0 and address==HALT_ADDR sets halt=1. The address then freezes until reset.
- Reset mid-instruction clears pending and take_q; fetch restarts at RESET_VECTOR.
- At most one address update per instruction, with a latency of one instruction. Behaviour when flags are sampled outside exec1 is undefined.

Decomposition:
- cpu_pkg holds:
  - the internal_code enum (codes above);
  - the INSTR_BYTES=4 constant;
  - the link-class and branch-class helper functions.
- One combinational sub-module, branch_resolver (internal_code plus flags in, taken/is_link/is_reg out). It is reused by the register-writeback control.

Test Plan:
- Reset, then three non-jump instructions: address = BFC00000, BFC00004, BFC00008, BFC0000C. halt=0 throughout.
- JR with register_data=4 at BFC00000: next address BFC00004 with in_delay_slot=1, then 00000004.
- BEQ at 0x100, offset=4, zero=1: addresses 0x104 then 0x114. Repeat with zero=0: 0x104 then 0x108. BNE with zero=1 is not taken.
- JAL at 0x200, instr_index=0x1000: link_en=1 and link_address=0x208 during exec1/exec2, then addresses 0x204 then 0x4000. BLTZAL not taken (positive=1): link_en=1, link_address=PC+8, sequential flow.
- Hold stall=1 for 3 cycles during exec2 after a taken J: address and pending are unchanged; after release the delay-slot and target sequence completes as normal. Assert reset during exec1 with pending=1: address=BFC00000 asynchronously, and the pending target is never applied.
- JR to 0: halt rises on the fetch of 0 and address stays 0 for 20 cycles. With DELAY_SLOT=0, J at 0x10 to 0x40 gives next address 0x40 and in_delay_slot=0.
